// File: rtl/lane_serializer_32_8_pkg.sv
// rtl/lane_serializer_32_8_pkg.sv - shared widths, symbols and state type for the lane datapath
// Purpose: constants and FSM state type shared by the striping demux, the
//          lane serializer and the per-lane parallel-to-serial stage.
// Ports:   none (package).
package lane_serializer_32_8_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  // Idle/COM symbol driven whenever a byte lane carries no payload.
  localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/lane_serializer_32_8_if.sv
// rtl/lane_serializer_32_8_if.sv - lane word input / byte output bundle
// Purpose: groups the lane word input, the byte output and the FIFO status.
// Ports:   data_in/valid_in (word from demux), data_out/valid_out (byte out),
//          fifo_full/fifo_empty/overflow (status).
//          slave  : serializer side (consumes words, drives bytes/status).
//          master : surrounding side (drives words, observes bytes/status).
interface lane_serializer_32_8_if
  import lane_serializer_32_8_pkg::*;
;
  logic [WORD_W-1:0] data_in;
  logic              valid_in;
  logic [BYTE_W-1:0] data_out;
  logic              valid_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;

  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out, fifo_full, fifo_empty, overflow
  );

  modport master (
    output data_in, valid_in,
    input  data_out, valid_out, fifo_full, fifo_empty, overflow
  );
endinterface

// File: rtl/lane_serializer_32_8_fifo_sync.sv
// rtl/lane_serializer_32_8_fifo_sync.sv - synchronous FIFO with combinational head
// Purpose: small single-clock FIFO; head entry is visible on o_rdata without a
//          read cycle, so the consumer can pop and use the word at one edge.
// Ports:   i_clk, i_reset_L (sync, active-low), i_push/i_wdata (write),
//          i_pop (consume head), o_rdata (head), o_full, o_empty, o_count.
module lane_serializer_32_8_fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_L,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A push into a full FIFO is legal when the head leaves at the same edge:
  // the slot being written is the one being vacated.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge i_clk) begin
    if (!i_reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/lane_serializer_32_8.sv
// rtl/lane_serializer_32_8.sv - per-lane word buffer and MSB-first byte serializer
// Purpose: buffers 32-bit lane words and emits each as four bytes, MSB first,
//          one per clk_4f cycle; drives IDLE_SYM with valid_out low when idle.
// Ports:   clk_4f (clock), reset_L (sync, active-low),
//          lane (slave modport: data_in/valid_in in; data_out/valid_out,
//          fifo_full/fifo_empty/overflow out).
module lane_serializer_32_8
  import lane_serializer_32_8_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter logic [BYTE_W-1:0] IDLE_SYM   = COM_SYM
) (
  input logic                   clk_4f,
  input logic                   reset_L,
  lane_serializer_32_8_if.slave lane
);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
  logic [23:0]       r_shift, w_shift_nxt;
  logic [BYTE_W-1:0] r_data_out, w_data_out_nxt;
  logic              r_valid_out, w_valid_out_nxt;
  logic              r_overflow;

  logic              w_pop_slot;
  logic              w_pop;
  logic              w_push;
  logic [WORD_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  lane_serializer_32_8_fifo_sync #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clk_4f),
    .i_reset_L (reset_L),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (lane.data_in),
    .o_rdata   (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // byte_cnt returns to 0 right after the last byte, so a pop in that cycle
  // keeps the stream gapless; in IDLE byte_cnt is also 0.
  assign w_pop_slot = (r_state == IDLE) || (r_byte_cnt == 2'd0);
  assign w_pop      = w_pop_slot && !w_empty;
  assign w_push     = lane.valid_in && (!w_full || w_pop);

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      r_state     <= IDLE;
      r_byte_cnt  <= 2'd0;
      r_shift     <= '0;
      r_data_out  <= IDLE_SYM;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_data_out  <= w_data_out_nxt;
      r_valid_out <= w_valid_out_nxt;
      if (lane.valid_in && !w_push) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_shift_nxt     = r_shift;
    w_data_out_nxt  = IDLE_SYM;
    w_valid_out_nxt = 1'b0;
    if (w_pop) begin
      w_data_out_nxt  = w_head[31:24];
      w_valid_out_nxt = 1'b1;
      w_shift_nxt     = w_head[23:0];
      w_byte_cnt_nxt  = 2'd1;
      w_state_nxt     = SHIFT;
    end else if (w_pop_slot) begin
      w_state_nxt    = IDLE;
      w_byte_cnt_nxt = 2'd0;
    end else begin
      w_valid_out_nxt = 1'b1;
      case (r_byte_cnt)
        2'd1: begin
          w_data_out_nxt = r_shift[23:16];
          w_byte_cnt_nxt = 2'd2;
        end
        2'd2: begin
          w_data_out_nxt = r_shift[15:8];
          w_byte_cnt_nxt = 2'd3;
        end
        default: begin
          w_data_out_nxt = r_shift[7:0];
          w_byte_cnt_nxt = 2'd0;
        end
      endcase
    end
  end

  assign lane.data_out   = r_data_out;
  assign lane.valid_out  = r_valid_out;
  assign lane.fifo_full  = (w_count == CNT_W'(FIFO_DEPTH));
  assign lane.fifo_empty = w_empty;
  assign lane.overflow   = r_overflow;
endmodule

// File: tb/tb_lane_serializer_32_8.sv
// tb/tb_lane_serializer_32_8.sv - self-checking bench for lane_serializer_32_8
module tb_lane_serializer_32_8;
  logic clk_4f = 1'b0;
  logic reset_L;

  lane_serializer_32_8_if u_if ();

  lane_serializer_32_8 #(
    .FIFO_DEPTH (4),
    .IDLE_SYM   (8'hBC)
  ) u_dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .lane    (u_if.slave)
  );

  always #5 clk_4f = ~clk_4f;

  int n_vec = 0;
  int n_err = 0;

  // Reference: a queue of buffered words and a queue of bytes still owed
  // for the word currently on the wire.
  logic [31:0] m_q[$];
  logic [7:0]  m_bytes[$];
  bit          m_ovf   = 1'b0;
  logic [7:0]  m_data  = 8'hBC;
  bit          m_valid = 1'b0;

  logic [7:0]  obs_bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rstn, input bit vin, input logic [31:0] din);
    bit          take;
    logic [31:0] w;
    if (!rstn) begin
      m_q.delete();
      m_bytes.delete();
      m_ovf   = 1'b0;
      m_data  = 8'hBC;
      m_valid = 1'b0;
      return;
    end
    // A new word starts only once every byte of the previous one is out.
    take = (m_bytes.size() == 0) && (m_q.size() > 0);
    if (take) begin
      w = m_q.pop_front();
      m_bytes.push_back(w[31:24]);
      m_bytes.push_back(w[23:16]);
      m_bytes.push_back(w[15:8]);
      m_bytes.push_back(w[7:0]);
    end
    if (vin) begin
      if (m_q.size() < 4) m_q.push_back(din);
      else                m_ovf = 1'b1;
    end
    if (m_bytes.size() > 0) begin
      m_data  = m_bytes.pop_front();
      m_valid = 1'b1;
    end else begin
      m_data  = 8'hBC;
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit rstn, input bit vin, input logic [31:0] din);
    reset_L        = rstn;
    u_if.valid_in  = vin;
    u_if.data_in   = din;
    @(posedge clk_4f);
    model_edge(rstn, vin, din);
    @(negedge clk_4f);
    if (u_if.valid_out === 1'b1) obs_bytes.push_back(u_if.data_out);
    chk("data_out",   {24'd0, u_if.data_out}, {24'd0, m_data});
    chk("valid_out",  {31'd0, u_if.valid_out}, {31'd0, m_valid});
    chk("fifo_full",  {31'd0, u_if.fifo_full}, {31'd0, (m_q.size() == 4)});
    chk("fifo_empty", {31'd0, u_if.fifo_empty}, {31'd0, (m_q.size() == 0)});
    chk("overflow",   {31'd0, u_if.overflow}, {31'd0, m_ovf});
  endtask

  initial begin
    logic [7:0]  exp_db[4];
    logic [31:0] words[7];
    logic [31:0] w;
    exp_db = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    reset_L       = 1'b0;
    u_if.valid_in = 1'b0;
    u_if.data_in  = '0;

    // Reset held with valid_in toggling.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0], $urandom);
      chk("rst_data",  {24'd0, u_if.data_out}, 32'hBC);
      chk("rst_empty", {31'd0, u_if.fifo_empty}, 32'd1);
    end

    // Single word: DE AD BE EF then idle.
    step(1'b1, 1'b1, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("db_byte", {24'd0, u_if.data_out}, {24'd0, exp_db[i]});
    end
    step(1'b1, 1'b0, 32'h0);
    chk("db_idle", {31'd0, u_if.valid_out}, 32'd0);

    // Two words four cycles apart: contiguous bytes, FIFO never fills past 1.
    obs_bytes.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i == 0) || (i == 4), (i == 0) ? 32'h11223344 : 32'h55667788);
    end
    chk("gapless_cnt", obs_bytes.size(), 32'd8);
    for (int i = 0; i < 8 && i < obs_bytes.size(); i++)
      chk("gapless_byte", {24'd0, obs_bytes[i]}, 32'h11 * (i + 1));

    // Seven back-to-back words into a depth-4 FIFO: W6 dropped, W0..W5 out.
    obs_bytes.delete();
    for (int i = 0; i < 7; i++) begin
      words[i] = $urandom;
      step(1'b1, 1'b1, words[i]);
    end
    chk("ovf_after7", {31'd0, u_if.overflow}, 32'd1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'h0);
    chk("burst_cnt", obs_bytes.size(), 32'd24);
    for (int i = 0; i < 24 && i < obs_bytes.size(); i++) begin
      w = words[i / 4];
      chk("burst_byte", {24'd0, obs_bytes[i]}, {24'd0, w[31 - 8 * (i % 4) -: 8]});
    end

    // Reset mid-word with words queued: everything discarded.
    step(1'b1, 1'b1, 32'hDEADBEEF);
    step(1'b1, 1'b1, 32'hCAFEF00D);
    step(1'b1, 1'b1, 32'h01234567);
    chk("pre_rst_ad", {24'd0, u_if.data_out}, 32'hAD);
    step(1'b0, 1'b0, 32'h0);
    chk("mid_rst_data",  {24'd0, u_if.data_out}, 32'hBC);
    chk("mid_rst_empty", {31'd0, u_if.fifo_empty}, 32'd1);
    obs_bytes.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    chk("mid_rst_none", obs_bytes.size(), 32'd0);

    // Randomized traffic with varying load and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int load;
      load = (i / 500) % 3;
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 7) < (load == 0 ? 2 : (load == 1 ? 3 : 6))),
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
